// File: rtl/cplx_datapath.sv
// cplx_datapath: operand registers, accumulator and result register driven by
// the sequence controller's opcode {s2,s1,s0} and function flags {f2,f1,f0}.
// Reports sticky overflow and commits the accumulator on a qualified COMMIT.
// Optional feature macro: CPLX_DP_SAT_EN (f2=1 clamps overflowing ALU results
// instead of wrapping). Without it, f2 is ignored and every overflow wraps.
// W must be at least 4.

module cplx_datapath #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s2,
    input  logic         s1,
    input  logic         s0,
    input  logic         f2,
    input  logic         f1,
    input  logic         f0,
    input  logic         done,
    input  logic         error,
    input  logic [W-1:0] din_a,
    input  logic [W-1:0] din_b,
    output logic         ovf,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic [3:0]   op_count
);

    // Exact ALU width: wide enough for a W x W signed product plus margin.
    localparam int XW = 2 * W + 2;

    typedef enum logic [2:0] {
        OP_CLR    = 3'b000,
        OP_LDA    = 3'b001,
        OP_LDB    = 3'b010,
        OP_ALU    = 3'b011,
        OP_COMMIT = 3'b111
    } opcode_e;

    logic [W-1:0]         rega_q, rega_d;
    logic [W-1:0]         regb_q, regb_d;
    logic [W-1:0]         acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [W-1:0]         result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic [3:0]           op_count_q, op_count_d;

    logic signed [XW-1:0] a_x, b_x, exact;
    logic [XW-W:0]        exact_hi;
    logic                 alu_ovf;
    logic                 sat_sel;
    logic [W-1:0]         alu_val;
    opcode_e              opcode;

    assign opcode = opcode_e'({s2, s1, s0});

`ifdef CPLX_DP_SAT_EN
    assign sat_sel = f2;
`else
    logic unused_f2;
    assign sat_sel   = 1'b0;
    assign unused_f2 = f2;
`endif

    // Exact ALU result, overflow detection and wrap/clamp of the value for acc.
    always_comb begin
        a_x = {{(XW - W){rega_q[W-1]}}, rega_q};
        b_x = {{(XW - W){regb_q[W-1]}}, regb_q};
        exact = '0;
        case ({f1, f0})
            2'b00:   exact = a_x + b_x;
            2'b01:   exact = a_x - b_x;
            2'b10:   exact = a_x * b_x;
            default: exact = (a_x <<< 1) + b_x;
        endcase
        // In range iff every bit from W-1 upward equals the sign bit.
        exact_hi = exact[XW-1:W-1];
        alu_ovf  = !((exact_hi == '0) || (exact_hi == '1));
        alu_val  = exact[W-1:0];
        if (alu_ovf && sat_sel) begin
            alu_val = exact[XW-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
        end
    end

    // Next-state decode; error freezes everything and suppresses result_valid.
    always_comb begin
        rega_d         = rega_q;
        regb_d         = regb_q;
        acc_d          = acc_q;
        ovf_d          = ovf_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        op_count_d     = op_count_q;
        if (!error) begin
            case (opcode)
                OP_CLR: begin
                    acc_d      = '0;
                    ovf_d      = 1'b0;
                    op_count_d = '0;
                end
                OP_LDA: rega_d = din_a;
                OP_LDB: regb_d = din_b;
                OP_ALU: begin
                    acc_d = alu_val;
                    if (alu_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (op_count_q != 4'd15) begin
                        op_count_d = op_count_q + 4'd1;
                    end
                end
                OP_COMMIT: begin
                    if (done) begin
                        result_d       = acc_q;
                        result_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rega_q         <= '0;
            regb_q         <= '0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            rega_q         <= rega_d;
            regb_q         <= regb_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            op_count_q     <= op_count_d;
        end
    end

    assign ovf          = ovf_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign op_count     = op_count_q;

endmodule
